fifo_param: RTL

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// Parameterised show-ahead FIFO with per-entry error tag, trigger level and
// one-cycle underrun/overrun pulses (16550-style receive/transmit FIFO).
module fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             err_in,
  input  logic [AW:0]      threshold,
  output logic [WIDTH-1:0] dout,
  output logic             dout_err,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level,
  output logic             underrun,
  output logic             overrun,
  output logic             thre_trig,
  output logic             err_pending
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    lvl_q;
  logic [AW:0]    err_cnt;
  logic           head_err;

  // Request semantics: push_in/pop_in are single-cycle requests sampled on
  // the rising edge when en=1 and flush=0; there is no ready/backpressure.
  // A rejected request is reported one cycle later via overrun/underrun.
  // When full, a push is still accepted if a valid pop happens in the same
  // cycle; when empty, a same-cycle pop never sees the incoming word.
  logic act;
  logic do_pop;
  logic do_push;
  logic under_nxt;
  logic over_nxt;

  always_comb begin
    act       = en & ~flush;
    do_pop    = act & pop_in & ~empty;
    do_push   = act & push_in & (~full | do_pop);
    under_nxt = act & pop_in & empty;
    over_nxt  = act & push_in & full & ~do_pop;
  end

  assign empty       = (lvl_q == '0);
  assign full        = (lvl_q == FULL_LVL);
  assign level       = lvl_q;
  assign head_err    = mem[rd_ptr][WIDTH];
  assign dout        = mem[rd_ptr][WIDTH-1:0];
  assign dout_err    = ~empty & head_err;
  assign thre_trig   = (threshold != '0) && (lvl_q >= threshold);
  assign err_pending = (err_cnt != '0);

  // Storage is not reset; only the control state defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {err_in, din};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl_q    <= '0;
      err_cnt  <= '0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else if (en && flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl_q    <= '0;
      err_cnt  <= '0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= under_nxt;
      overrun  <= over_nxt;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
      // A tagged push and a tagged head pop in the same cycle cancel out.
      case ({do_push & err_in, do_pop & head_err})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: err_cnt <= err_cnt;
      endcase
    end
  end

endmodule
